spu_issue_scoreboard: RTL and testbench

- Parametrised dual-issue hazard controller for the SPU pipeline; sits between the IF_ID register and the decode/execute stages.
- Each cycle it receives one even-pipe and one odd-pipe instruction descriptor. It tracks in-flight destination registers with per-register latency countdowns.
- It decides which of the pair may issue under in-order, RAW-safe and WAW-safe rules, and replaces the single-instruction reset-only control path.

---
 rtl/spu_issue_scoreboard.sv | 108 ++++++++++
 tb/tb_spu_issue_scoreboard.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/spu_issue_scoreboard.sv
// Dual-issue hazard controller: per-register latency countdowns gate RAW/WAW-safe in-order issue.
// Optional stall-cycle counter enabled by defining SPU_STALL_CNT_EN.
module spu_issue_scoreboard #(
  parameter int unsigned REG_ADDR_W  = 7,
  parameter int unsigned LAT_W       = 3,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   ev_valid,
  input  logic [REG_ADDR_W-1:0]  ev_ra,
  input  logic [REG_ADDR_W-1:0]  ev_rb,
  input  logic [REG_ADDR_W-1:0]  ev_rc,
  input  logic [2:0]             ev_src_use,
  input  logic                   ev_rt_we,
  input  logic [REG_ADDR_W-1:0]  ev_rt,
  input  logic [LAT_W-1:0]       ev_lat,
  input  logic                   od_valid,
  input  logic [REG_ADDR_W-1:0]  od_ra,
  input  logic [REG_ADDR_W-1:0]  od_rb,
  input  logic [REG_ADDR_W-1:0]  od_rc,
  input  logic [2:0]             od_src_use,
  input  logic                   od_rt_we,
  input  logic [REG_ADDR_W-1:0]  od_rt,
  input  logic [LAT_W-1:0]       od_lat,
  output logic                   ev_issue,
  output logic                   od_issue,
  output logic                   stall,
  output logic                   sb_busy,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int unsigned NumRegs = 2 ** REG_ADDR_W;

  logic [LAT_W-1:0] sb_q [NumRegs];
  logic             started_q;
  logic             ev_src_ok, od_src_ok, ev_waw_ok, od_waw_ok;
  logic             od_raw, od_waw_pair;
  logic             ev_wr, od_wr;

  // Outputs stay quiet on the first cycle after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) started_q <= 1'b0;
    else        started_q <= 1'b1;
  end

  always_comb begin
    ev_src_ok = (!ev_src_use[0] || sb_q[ev_ra] == '0) &&
                (!ev_src_use[1] || sb_q[ev_rb] == '0) &&
                (!ev_src_use[2] || sb_q[ev_rc] == '0);
    od_src_ok = (!od_src_use[0] || sb_q[od_ra] == '0) &&
                (!od_src_use[1] || sb_q[od_rb] == '0) &&
                (!od_src_use[2] || sb_q[od_rc] == '0);
    ev_waw_ok = !ev_rt_we || (sb_q[ev_rt] <= ev_lat);
    od_waw_ok = !od_rt_we || (sb_q[od_rt] <= od_lat);

    ev_issue = started_q && ev_valid && !flush && ev_src_ok && ev_waw_ok;

    od_raw = ev_rt_we && ((od_src_use[0] && od_ra == ev_rt) ||
                          (od_src_use[1] && od_rb == ev_rt) ||
                          (od_src_use[2] && od_rc == ev_rt));
    od_waw_pair = ev_rt_we && od_rt_we && (ev_rt == od_rt);

    od_issue = started_q && od_valid && !flush && od_src_ok && od_waw_ok &&
               (!ev_valid || ev_issue) && !(ev_issue && (od_raw || od_waw_pair));

    stall = started_q && !flush &&
            ((ev_valid && !ev_issue) || (od_valid && !od_issue));

    ev_wr = ev_issue && ev_rt_we && (ev_lat != '0);
    od_wr = od_issue && od_rt_we && (od_lat != '0);
  end

  // A new write overrides the countdown; zero latency leaves the entry untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NumRegs; r++) sb_q[r] <= '0;
    end else begin
      for (int r = 0; r < NumRegs; r++) begin
        if (ev_wr && ev_rt == REG_ADDR_W'(r))      sb_q[r] <= ev_lat;
        else if (od_wr && od_rt == REG_ADDR_W'(r)) sb_q[r] <= od_lat;
        else if (sb_q[r] != '0)                    sb_q[r] <= sb_q[r] - 1'b1;
      end
    end
  end

  always_comb begin
    sb_busy = 1'b0;
    for (int r = 0; r < NumRegs; r++) begin
      if (sb_q[r] != '0) sb_busy = 1'b1;
    end
  end

`ifdef SPU_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       stall_cnt_q <= '0;
    else if (stall && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_spu_issue_scoreboard.sv
// Directed table-driven bench for spu_issue_scoreboard plus hand-written reset sequences.
module tb_spu_issue_scoreboard;

  typedef struct packed {
    logic       v;
    logic [6:0] ra, rb, rc;
    logic [2:0] src;
    logic       we;
    logic [6:0] rt;
    logic [2:0] lat;
  } desc_t;

  typedef struct {
    string name;
    logic  flush;
    desc_t ev, od;
    logic  e_ev, e_od, e_st, e_busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        ev_valid, ev_rt_we, od_valid, od_rt_we;
  logic [6:0]  ev_ra, ev_rb, ev_rc, ev_rt, od_ra, od_rb, od_rc, od_rt;
  logic [2:0]  ev_src_use, ev_lat, od_src_use, od_lat;
  logic        ev_issue, od_issue, stall, sb_busy;
  logic [15:0] stall_cycles;

  int   total = 0;
  int   bad = 0;
  int   exp_cnt = 0;
  vec_t vecs[$];

  spu_issue_scoreboard dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ev_valid(ev_valid), .ev_ra(ev_ra), .ev_rb(ev_rb), .ev_rc(ev_rc),
    .ev_src_use(ev_src_use), .ev_rt_we(ev_rt_we), .ev_rt(ev_rt), .ev_lat(ev_lat),
    .od_valid(od_valid), .od_ra(od_ra), .od_rb(od_rb), .od_rc(od_rc),
    .od_src_use(od_src_use), .od_rt_we(od_rt_we), .od_rt(od_rt), .od_lat(od_lat),
    .ev_issue(ev_issue), .od_issue(od_issue), .stall(stall), .sb_busy(sb_busy),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  localparam desc_t Idle = '0;

  function automatic desc_t wr(logic [6:0] rt, logic [2:0] lat);
    desc_t x = '0;
    x.v = 1'b1; x.we = 1'b1; x.rt = rt; x.lat = lat;
    return x;
  endfunction

  function automatic desc_t rd(logic [6:0] r, logic [2:0] src);
    desc_t x = '0;
    x.v = 1'b1; x.ra = r; x.rb = r; x.rc = r; x.src = src;
    return x;
  endfunction

  task automatic add(string n, logic f, desc_t e, desc_t o,
                     logic ee, logic eo, logic es, logic eb);
    vec_t v;
    v.name = n; v.flush = f; v.ev = e; v.od = o;
    v.e_ev = ee; v.e_od = eo; v.e_st = es; v.e_busy = eb;
    vecs.push_back(v);
  endtask

  task automatic drive(logic f, desc_t e, desc_t o);
    flush = f;
    ev_valid = e.v; ev_ra = e.ra; ev_rb = e.rb; ev_rc = e.rc; ev_src_use = e.src;
    ev_rt_we = e.we; ev_rt = e.rt; ev_lat = e.lat;
    od_valid = o.v; od_ra = o.ra; od_rb = o.rb; od_rc = o.rc; od_src_use = o.src;
    od_rt_we = o.we; od_rt = o.rt; od_lat = o.lat;
  endtask

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  initial begin
    // Independent pair, then consumers confirm sb[6]=2,1,0 and sb[5]=...,1,0.
    add("pair",      0, wr(5, 4),        wr(6, 2), 1, 1, 0, 0);
    add("c6a",       0, rd(6, 3'b001),   Idle,     0, 0, 1, 1);
    add("c6b",       0, rd(6, 3'b001),   Idle,     0, 0, 1, 1);
    add("c6go",      0, rd(6, 3'b001),   Idle,     1, 0, 0, 1);
    add("c5a",       0, rd(5, 3'b001),   Idle,     0, 0, 1, 1);
    add("c5go",      0, rd(5, 3'b001),   Idle,     1, 0, 0, 0);
    // RAW: three held cycles
    add("raw_w",     0, wr(10, 3),       Idle,     1, 0, 0, 0);
    add("raw1",      0, rd(10, 3'b001),  Idle,     0, 0, 1, 1);
    add("raw2",      0, rd(10, 3'b001),  Idle,     0, 0, 1, 1);
    add("raw3",      0, rd(10, 3'b001),  Idle,     0, 0, 1, 1);
    add("raw_go",    0, rd(10, 3'b001),  Idle,     1, 0, 0, 0);
    // Intra-pair RAW on rb, then odd re-presented alone
    add("ip_raw",    0, wr(20, 2),       rd(20, 3'b010), 1, 0, 1, 0);
    add("ip_od1",    0, Idle,            rd(20, 3'b010), 0, 0, 1, 1);
    add("ip_od2",    0, Idle,            rd(20, 3'b010), 0, 0, 1, 1);
    add("ip_odgo",   0, Idle,            rd(20, 3'b010), 0, 1, 0, 0);
    // In-order: blocked even holds a ready odd
    add("io_w",      0, wr(30, 1),       rd(1, 3'b000),  1, 1, 0, 0);
    add("io_hold",   0, rd(30, 3'b001),  rd(1, 3'b000),  0, 0, 1, 1);
    add("io_idle",   0, Idle,            Idle,     0, 0, 0, 0);
    // WAW: sb[7] 6,5,4,3 hold; issue at 2; new lat=2 overrides decrement
    add("waw_w",     0, wr(7, 6),        Idle,     1, 0, 0, 0);
    add("waw6",      0, wr(7, 2),        Idle,     0, 0, 1, 1);
    add("waw5",      0, wr(7, 2),        Idle,     0, 0, 1, 1);
    add("waw4",      0, wr(7, 2),        Idle,     0, 0, 1, 1);
    add("waw3",      0, wr(7, 2),        Idle,     0, 0, 1, 1);
    add("waw_go",    0, wr(7, 2),        Idle,     1, 0, 0, 1);
    add("waw_c2",    0, rd(7, 3'b001),   Idle,     0, 0, 1, 1);
    add("waw_c1",    0, rd(7, 3'b001),   Idle,     0, 0, 1, 1);
    add("waw_cgo",   0, rd(7, 3'b001),   Idle,     1, 0, 0, 0);
    // Intra-pair WAW
    add("ip_waw",    0, wr(40, 1),       wr(40, 3), 1, 0, 1, 0);
    add("ip_waw_b",  0, Idle,            Idle,     0, 0, 0, 1);
    add("ip_waw_i",  0, Idle,            Idle,     0, 0, 0, 0);
    // Zero latency never blocks
    add("lat0_w",    0, wr(50, 0),       Idle,     1, 0, 0, 0);
    add("lat0_r",    0, rd(50, 3'b001),  Idle,     1, 0, 0, 0);
    // Flush: no issue, no stall, countdowns continue, flushed writes dropped
    add("fl_w",      0, wr(60, 3),       Idle,     1, 0, 0, 0);
    add("flush",     1, wr(61, 2),       wr(62, 2), 0, 0, 0, 1);
    add("fl_after",  0, rd(61, 3'b001),  rd(62, 3'b100), 1, 1, 0, 1);
    add("fl_c60",    0, rd(60, 3'b001),  Idle,     0, 0, 1, 1);
    add("fl_c60go",  0, rd(60, 3'b001),  Idle,     1, 0, 0, 0);
    // Register 0 is tracked
    add("r0_w",      0, wr(0, 1),        Idle,     1, 0, 0, 0);
    add("r0_hold",   0, rd(0, 3'b100),   Idle,     0, 0, 1, 1);
    add("r0_go",     0, rd(0, 3'b100),   Idle,     1, 0, 0, 0);

    reset = 1'b0;
    drive(1'b0, Idle, Idle);
    repeat (3) @(posedge clk);
    @(negedge clk);
    drive(1'b0, wr(1, 1), Idle);
    #1;
    chk("rst_ev", ev_issue, 0);
    chk("rst_busy", sb_busy, 0);
    chk("rst_cnt", stall_cycles, 0);
    reset = 1'b1;
    #1;
    chk("rel_ev", ev_issue, 0);
    chk("rel_stall", stall, 0);
    chk("rel_busy", sb_busy, 0);
    @(negedge clk);
    drive(1'b0, Idle, Idle);
    #1;
    chk("idle_ev", ev_issue, 0);
    chk("idle_busy", sb_busy, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].flush, vecs[i].ev, vecs[i].od);
      #1;
      chk({vecs[i].name, ".ev"}, ev_issue, vecs[i].e_ev);
      chk({vecs[i].name, ".od"}, od_issue, vecs[i].e_od);
      chk({vecs[i].name, ".stall"}, stall, vecs[i].e_st);
      chk({vecs[i].name, ".busy"}, sb_busy, vecs[i].e_busy);
`ifdef SPU_STALL_CNT_EN
      if (vecs[i].e_st) exp_cnt++;
`endif
    end

    // Counter snapshot, then reset mid-operation with sb[3]=5
    @(negedge clk);
    drive(1'b0, wr(3, 5), Idle);
    #1;
    chk("cnt", stall_cycles, exp_cnt);
    chk("r3_w", ev_issue, 1);
    @(negedge clk);
    drive(1'b0, rd(3, 3'b001), Idle);
    #1;
    chk("r3_busy", sb_busy, 1);
    chk("r3_hold", ev_issue, 0);
    reset = 1'b0;
    #1;
    chk("mid_busy", sb_busy, 0);
    chk("mid_cnt", stall_cycles, 0);
    chk("mid_ev", ev_issue, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rel_ev", ev_issue, 0);
    chk("mid_rel_stall", stall, 0);
    @(negedge clk);
    #1;
    chk("mid_go_ev", ev_issue, 1);
    chk("mid_go_stall", stall, 0);
    chk("mid_go_busy", sb_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
